// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction/PC widths, PC step and instruction-loader state encoding
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 6;
  localparam int PC_STEP = 2;
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CKSUM, S_DONE, S_ERR} loader_state_t;
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: 8->32 MSB-first byte packer with 2-bit byte counter
module imem_word_assembler
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);
  logic [1:0] cnt;
  assign word_valid = byte_valid && cnt == 2'd3;
  always_ff @(posedge clk)
    if (reset || clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (byte_valid) begin
      word <= {word[INSTR_W-9:0], byte_in};
      cnt  <= cnt + 2'd1;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instr_mem, holding the CPU in reset; IMEM_LOADER_CKSUM_EN adds a trailing XOR checksum byte
module imem_loader
  import cpu_pkg::*;
#(
  parameter int             MAX_WORDS = 32,
  parameter int             ADDR_STEP = PC_STEP,
  parameter logic [PC_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);
  loader_state_t state;
  logic [CW-1:0] words_left;
  logic xfer, start_ok, word_valid;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] cksum;
`endif
  assign rx_ready = state inside {S_COUNT, S_DATA, S_CKSUM};
  assign xfer = rx_valid && rx_ready;
  assign start_ok = start && state inside {S_IDLE, S_DONE, S_ERR};
  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (xfer && state == S_DATA),
    .byte_in    (rx_data),
    .word       (imem_wdata),
    .word_valid (word_valid)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_left <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        state     <= S_COUNT;
        cpu_hold  <= 1'b1;
        done      <= 1'b0;
        err       <= 1'b0;
        imem_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum     <= '0;
`endif
      end else begin
        case (state)
          S_COUNT:
            if (xfer) begin
              if (rx_data == 8'd0 || rx_data > MAX_N) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else begin
                words_left <= CW'(rx_data);
                state      <= S_DATA;
              end
            end
          S_DATA:
            if (xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
              cksum <= cksum ^ rx_data;
`endif
              if (word_valid) begin
                state   <= S_WRITE;
                imem_we <= 1'b1;
              end
            end
          S_WRITE: begin
            imem_addr  <= imem_addr + PC_W'(ADDR_STEP);
            words_left <= words_left - CW'(1);
            if (words_left != CW'(1))
              state <= S_DATA;
`ifdef IMEM_LOADER_CKSUM_EN
            else
              state <= S_CKSUM;
`else
            else begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
`endif
          end
`ifdef IMEM_LOADER_CKSUM_EN
          S_CKSUM:
            if (xfer) begin
              state    <= (rx_data == cksum) ? S_DONE : S_ERR;
              done     <= rx_data == cksum;
              err      <= rx_data != cksum;
              cpu_hold <= rx_data != cksum;
            end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; dut_a uses defaults, dut_b has BASE_ADDR=2 for the wrap case
module tb_imem_loader;
  typedef struct {logic [5:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [7:0] cnt; bit jitter; bit exp_done;} vec_t;
  logic clk = 0, reset_a = 1, reset_b = 1, start = 0, rx_valid = 0, sel = 0;
  logic [7:0] rx_data = 0;
  logic rdy_a, we_a, hold_a, done_a, err_a, rdy_b, we_b, hold_b, done_b, err_b;
  logic [5:0] addr_a, addr_b;
  logic [31:0] wd_a, wd_b;
  logic rdy, we, hold, done, err;
  logic [5:0] addr;
  logic [31:0] wd;
  int checks = 0, fails = 0, nwrites = 0;
  bit mon_en = 0;
  wr_t q[$];
  logic [31:0] prog[64];
  vec_t tbl[6];
  always #5 clk = ~clk;
  imem_loader dut_a (
    .clk(clk), .reset(reset_a), .start(start && !sel), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
    .cpu_hold(hold_a), .done(done_a), .err(err_a));
  imem_loader #(.MAX_WORDS(32), .BASE_ADDR(6'd2)) dut_b (
    .clk(clk), .reset(reset_b), .start(start && sel), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
    .cpu_hold(hold_b), .done(done_b), .err(err_b));
  assign rdy  = sel ? rdy_b  : rdy_a;
  assign we   = sel ? we_b   : we_a;
  assign hold = sel ? hold_b : hold_a;
  assign done = sel ? done_b : done_a;
  assign err  = sel ? err_b  : err_a;
  assign addr = sel ? addr_b : addr_a;
  assign wd   = sel ? wd_b   : wd_a;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (mon_en && we) begin
    wr_t e;
    nwrites++;
    chk("rx_ready_in_write", 32'(rdy), 0);
    chk("we_exclusive", 32'(done | err), 0);
    if (q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_write: got addr %h data %h expected no write", addr, wd);
    end else begin
      e = q.pop_front();
      chk("write_addr", 32'(addr), 32'(e.a));
      chk("write_data", wd, e.d);
    end
  end
  task automatic send_byte(input logic [7:0] b, input bit jitter);
    bit ok = 0;
    if (jitter) repeat ($urandom_range(0, 2)) begin
      rx_valid = 0;
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1;
    rx_data = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = rdy;
      @(negedge clk);
    end
    rx_valid = 0;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL byte_accept_timeout: got rx_ready low for 50 cycles expected byte %h taken", b);
    end
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic do_load(input logic [7:0] cnt, input int n, input logic [5:0] base, input bit jitter,
                         input bit bad_ck);
    logic [7:0] ck = 0;
    logic [5:0] a = base;
    logic [7:0] b;
    pulse_start();
    send_byte(cnt, jitter);
    for (int i = 0; i < n; i++) begin
      q.push_back('{a, prog[i]});
      a = a + 6'd2;
      for (int k = 3; k >= 0; k--) begin
        b = prog[i][8*k +: 8];
        ck ^= b;
        send_byte(b, jitter);
      end
    end
`ifdef IMEM_LOADER_CKSUM_EN
    if (n > 0) send_byte(bad_ck ? ~ck : ck, jitter);
`else
    if (bad_ck) $display("note: checksum feature disabled, bad checksum not sent");
`endif
  endtask
  task automatic wait_end(input string name, input bit exp_done);
    for (int i = 0; i < 20 && !(done || err); i++) @(negedge clk);
    chk({name, "_done"}, 32'(done), 32'(exp_done));
    chk({name, "_err"}, 32'(err), 32'(!exp_done));
    chk({name, "_cpu_hold"}, 32'(hold), 32'(!exp_done));
    chk({name, "_pending_writes"}, q.size(), 0);
    q.delete();
  endtask
  initial begin
    tbl[0] = '{8'd0, 0, 0};
    tbl[1] = '{8'd33, 0, 0};
    tbl[2] = '{8'hFF, 1, 0};
    tbl[3] = '{8'd1, 1, 1};
    tbl[4] = '{8'd3, 1, 1};
    tbl[5] = '{8'd32, 0, 1};
    repeat (3) @(negedge clk);
    reset_a = 0;
    @(negedge clk);
    chk("reset_we", 32'(we), 0);
    chk("reset_addr", 32'(addr), 0);
    chk("reset_wdata", wd, 0);
    chk("reset_hold", 32'(hold), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    mon_en = 1;
    rx_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rx_ready", 32'(rdy), 0);
    end
    rx_valid = 0;
    prog[0] = 32'hDEADBEEF;
    prog[1] = 32'h00000013;
    do_load(8'd2, 2, 6'd0, 0, 0);
    wait_end("basic", 1);
    do_load(8'd2, 2, 6'd0, 1, 0);
    wait_end("jitter", 1);
`ifdef IMEM_LOADER_CKSUM_EN
    nwrites = 0;
    do_load(8'd2, 2, 6'd0, 0, 1);
    wait_end("bad_cksum", 0);
    chk("bad_cksum_writes", nwrites, 2);
`endif
    foreach (tbl[i]) begin
      for (int j = 0; j < 32; j++) prog[j] = $urandom;
      nwrites = 0;
      do_load(tbl[i].cnt, tbl[i].exp_done ? int'(tbl[i].cnt) : 0, 6'd0, tbl[i].jitter, 0);
      wait_end($sformatf("table%0d", i), tbl[i].exp_done);
      chk($sformatf("table%0d_writes", i), nwrites, tbl[i].exp_done ? 32'(tbl[i].cnt) : 0);
    end
    prog[0] = 32'h11223344;
    prog[1] = 32'h55667788;
    pulse_start();
    send_byte(8'd2, 0);
    q.push_back('{6'd0, prog[0]});
    for (int k = 3; k >= 0; k--) send_byte(prog[0][8*k +: 8], 0);
    send_byte(prog[1][31:24], 0);
    send_byte(prog[1][23:16], 0);
    reset_a = 1;
    @(negedge clk);
    chk("midreset_pending", q.size(), 0);
    chk("midreset_rx_ready", 32'(rdy), 0);
    chk("midreset_hold", 32'(hold), 0);
    chk("midreset_addr", 32'(addr), 0);
    chk("midreset_wdata", wd, 0);
    reset_a = 0;
    @(negedge clk);
    prog[0] = 32'hCAFEF00D;
    do_load(8'd1, 1, 6'd0, 0, 0);
    wait_end("restart", 1);
    sel = 1;
    reset_a = 1;
    reset_b = 0;
    @(negedge clk);
    for (int j = 0; j < 32; j++) prog[j] = $urandom;
    nwrites = 0;
    do_load(8'd32, 32, 6'd2, 0, 0);
    wait_end("wrap", 1);
    chk("wrap_strobes", nwrites, 32);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
